// File: rtl/pcie_cc_arb_pkg.sv
// pcie_cc_arb_pkg: arbiter state encoding and default CC widths
// shared by the PCIe completer-completion arbiter and its FIFO.
package pcie_cc_arb_pkg;

    localparam int CC_DATA_WIDTH = 512;
    localparam int CC_KEEP_WIDTH = 64;
    localparam int CC_USER_WIDTH = 81;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        GNT0 = 2'd1,
        GNT1 = 2'd2
    } arb_state_t;

endpackage

// File: rtl/pcie_cc_arbiter_fifo.sv
// cc_sync_fifo: single-clock FIFO with registered count and pointers.
// A push into a full FIFO succeeds when a pop frees a slot in the same cycle.
module cc_sync_fifo
    import pcie_cc_arb_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    count;
    logic             do_wr;
    logic             do_rd;

    assign full    = (count == FULL_CNT);
    assign empty   = (count == '0);
    assign do_rd   = rd_en && !empty;
    assign do_wr   = wr_en && (!full || do_rd);
    assign rd_data = mem[rd_ptr];

    // Pointer and occupancy bookkeeping; pointers wrap modulo DEPTH.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_wr) wr_ptr <= wr_ptr + 1'b1;
            if (do_rd) rd_ptr <= rd_ptr + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    // Storage array; contents need no reset since count gates reads.
    always_ff @(posedge clk) begin
        if (do_wr) mem[wr_ptr] <= wr_data;
    end

endmodule

// File: rtl/pcie_cc_arbiter.sv
// pcie_cc_arbiter: packet-boundary arbiter merging two CC streams.
// Option PCIE_CC_ARB_FIXED_PRIO_EN: port 0 always wins ties.
module pcie_cc_arbiter
    import pcie_cc_arb_pkg::*;
#(
    parameter int DATA_WIDTH    = CC_DATA_WIDTH,
    parameter int KEEP_WIDTH    = CC_KEEP_WIDTH,
    parameter int USER_WIDTH    = CC_USER_WIDTH,
    parameter int S0_FIFO_DEPTH = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s0_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s0_axis_tkeep,
    input  logic                  s0_axis_tlast,
    input  logic [USER_WIDTH-1:0] s0_axis_tuser,
    input  logic                  s0_axis_tvalid,
    output logic                  s0_axis_tready,
    output logic                  s0_overflow,
    input  logic [DATA_WIDTH-1:0] s1_axis_tdata,
    input  logic [KEEP_WIDTH-1:0] s1_axis_tkeep,
    input  logic                  s1_axis_tlast,
    input  logic [USER_WIDTH-1:0] s1_axis_tuser,
    input  logic                  s1_axis_tvalid,
    output logic                  s1_axis_tready,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic [KEEP_WIDTH-1:0] m_axis_tkeep,
    output logic                  m_axis_tlast,
    output logic [USER_WIDTH-1:0] m_axis_tuser,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready
);

    localparam int KO = DATA_WIDTH;
    localparam int UO = DATA_WIDTH + KEEP_WIDTH;
    localparam int FW = 1 + USER_WIDTH + KEEP_WIDTH + DATA_WIDTH;

    arb_state_t state;
    arb_state_t next_state;

    logic [FW-1:0]         f_wr;
    logic [FW-1:0]         f_rd;
    logic                  f_full;
    logic                  f_empty;
    logic [DATA_WIDTH-1:0] f_data;
    logic [KEEP_WIDTH-1:0] f_keep;
    logic [USER_WIDTH-1:0] f_user;
    logic                  f_last;

    logic load_en;
    logic req0;
    logic req1;
    logic win0;
    logic win1;
    logic pop;
    logic s1_rdy;
    logic s1_acc;

    assign f_wr = {s0_axis_tlast, s0_axis_tuser,
                   s0_axis_tkeep, s0_axis_tdata};

    cc_sync_fifo #(
        .WIDTH (FW),
        .DEPTH (S0_FIFO_DEPTH)
    ) u_s0_fifo (
        .clk     (clk),
        .rst     (rst),
        .wr_en   (s0_axis_tvalid),
        .wr_data (f_wr),
        .rd_en   (pop),
        .rd_data (f_rd),
        .full    (f_full),
        .empty   (f_empty)
    );

    assign f_data = f_rd[DATA_WIDTH-1:0];
    assign f_keep = f_rd[UO-1:KO];
    assign f_user = f_rd[FW-2:UO];
    assign f_last = f_rd[FW-1];

    assign s0_axis_tready = !f_full;
    assign load_en        = !m_axis_tvalid || m_axis_tready;
    assign req0           = !f_empty;
    assign req1           = s1_axis_tvalid;

`ifdef PCIE_CC_ARB_FIXED_PRIO_EN
    assign win0 = req0;
`else
    logic last_grant;
    assign win0 = req0 && (!req1 || last_grant);
`endif
    assign win1 = req1 && !win0;

    // Held low in reset so the upstream never sees a phantom accept.
    assign s1_axis_tready = s1_rdy && rst;
    assign s1_acc         = s1_axis_tready && s1_axis_tvalid;

    // Grant FSM state register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state <= IDLE;
        else      state <= next_state;
    end

    // Next state, FIFO pop and port-1 ready; locked to one port mid-packet.
    always_comb begin
        next_state = state;
        pop        = 1'b0;
        s1_rdy     = 1'b0;
        if (load_en) begin
            case (state)
                IDLE: begin
                    if (win0) begin
                        pop = 1'b1;
                        if (!f_last) next_state = GNT0;
                    end else if (win1) begin
                        s1_rdy = 1'b1;
                        if (!s1_axis_tlast) next_state = GNT1;
                    end
                end
                GNT0: begin
                    pop = req0;
                    if (req0 && f_last) next_state = IDLE;
                end
                GNT1: begin
                    s1_rdy = 1'b1;
                    if (s1_axis_tvalid && s1_axis_tlast) next_state = IDLE;
                end
                default: next_state = IDLE;
            endcase
        end
    end

`ifndef PCIE_CC_ARB_FIXED_PRIO_EN
    // Remember the last packet-start winner for round-robin ties.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            last_grant <= 1'b1;
        end else if (state == IDLE && load_en) begin
            if (win0)      last_grant <= 1'b0;
            else if (win1) last_grant <= 1'b1;
        end
    end
`endif

    // Sticky flag for a port-0 beat that found the FIFO full.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            s0_overflow <= 1'b0;
        end else if (s0_axis_tvalid && f_full && !pop) begin
            s0_overflow <= 1'b1;
        end
    end

    // Output register: reloads whenever it is empty or being drained.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            m_axis_tvalid <= 1'b0;
            m_axis_tdata  <= '0;
            m_axis_tkeep  <= '0;
            m_axis_tlast  <= 1'b0;
            m_axis_tuser  <= '0;
        end else if (load_en) begin
            m_axis_tvalid <= pop || s1_acc;
            if (pop) begin
                m_axis_tdata <= f_data;
                m_axis_tkeep <= f_keep;
                m_axis_tlast <= f_last;
                m_axis_tuser <= f_user;
            end else if (s1_acc) begin
                m_axis_tdata <= s1_axis_tdata;
                m_axis_tkeep <= s1_axis_tkeep;
                m_axis_tlast <= s1_axis_tlast;
                m_axis_tuser <= s1_axis_tuser;
            end
        end
    end

endmodule

// File: tb/tb_pcie_cc_arbiter.sv
// tb_pcie_cc_arbiter: directed and random checks of the CC arbiter
// against per-port ordering queues and packet-atomicity rules.
module tb_pcie_cc_arbiter;

    localparam int DW    = 512;
    localparam int KW    = 64;
    localparam int UW    = 81;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [DW-1:0] d;
        logic [KW-1:0] k;
        logic          l;
        logic [UW-1:0] u;
    } beat_t;

    logic          clk = 1'b0;
    logic          rst = 1'b0;
    logic [DW-1:0] s0_axis_tdata;
    logic [KW-1:0] s0_axis_tkeep;
    logic          s0_axis_tlast;
    logic [UW-1:0] s0_axis_tuser;
    logic          s0_axis_tvalid;
    logic          s0_axis_tready;
    logic          s0_overflow;
    logic [DW-1:0] s1_axis_tdata;
    logic [KW-1:0] s1_axis_tkeep;
    logic          s1_axis_tlast;
    logic [UW-1:0] s1_axis_tuser;
    logic          s1_axis_tvalid;
    logic          s1_axis_tready;
    logic [DW-1:0] m_axis_tdata;
    logic [KW-1:0] m_axis_tkeep;
    logic          m_axis_tlast;
    logic [UW-1:0] m_axis_tuser;
    logic          m_axis_tvalid;
    logic          m_axis_tready;

    always #5 clk = ~clk;

    pcie_cc_arbiter #(
        .DATA_WIDTH    (DW),
        .KEEP_WIDTH    (KW),
        .USER_WIDTH    (UW),
        .S0_FIFO_DEPTH (DEPTH)
    ) dut (
        .clk            (clk),
        .rst            (rst),
        .s0_axis_tdata  (s0_axis_tdata),
        .s0_axis_tkeep  (s0_axis_tkeep),
        .s0_axis_tlast  (s0_axis_tlast),
        .s0_axis_tuser  (s0_axis_tuser),
        .s0_axis_tvalid (s0_axis_tvalid),
        .s0_axis_tready (s0_axis_tready),
        .s0_overflow    (s0_overflow),
        .s1_axis_tdata  (s1_axis_tdata),
        .s1_axis_tkeep  (s1_axis_tkeep),
        .s1_axis_tlast  (s1_axis_tlast),
        .s1_axis_tuser  (s1_axis_tuser),
        .s1_axis_tvalid (s1_axis_tvalid),
        .s1_axis_tready (s1_axis_tready),
        .m_axis_tdata   (m_axis_tdata),
        .m_axis_tkeep   (m_axis_tkeep),
        .m_axis_tlast   (m_axis_tlast),
        .m_axis_tuser   (m_axis_tuser),
        .m_axis_tvalid  (m_axis_tvalid),
        .m_axis_tready  (m_axis_tready)
    );

    beat_t s0_pend[$];
    beat_t s1_pend[$];
    beat_t exp0[$];
    beat_t exp1[$];
    beat_t obs[$];

    int    s0_rate   = 100;
    int    s1_gap    = 0;
    int    mr_rate   = 100;
    int    errors    = 0;
    int    checks    = 0;
    int    stall_err = 0;
    bit    prev_stall = 1'b0;
    beat_t prev_beat;

    // Tag bit DW-1 holds the source port, DW-2..DW-32 a sequence number.
    function automatic beat_t mk(bit port, int seq, bit last);
        beat_t b;
        for (int i = 0; i < DW / 32; i++) b.d[i*32 +: 32] = $urandom;
        b.d[DW-1 -: 32] = {port, 31'(seq)};
        b.k = {$urandom, $urandom};
        b.u = UW'({$urandom, $urandom, $urandom});
        b.l = last;
        return b;
    endfunction

    function automatic beat_t cur_out();
        return {m_axis_tdata, m_axis_tkeep, m_axis_tlast, m_axis_tuser};
    endfunction

    task automatic chk(string tag, logic [63:0] got, logic [63:0] want);
        checks++;
        assert (got === want) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, want);
        end
    endtask

    task automatic drive0(beat_t b);
        s0_axis_tdata  = b.d;
        s0_axis_tkeep  = b.k;
        s0_axis_tlast  = b.l;
        s0_axis_tuser  = b.u;
        s0_axis_tvalid = 1'b1;
    endtask

    task automatic inject0(beat_t b, bit expect_kept);
        drive0(b);
        if (expect_kept) exp0.push_back(b);
    endtask

    task automatic drive1();
        s1_axis_tdata  = s1_pend[0].d;
        s1_axis_tkeep  = s1_pend[0].k;
        s1_axis_tlast  = s1_pend[0].l;
        s1_axis_tuser  = s1_pend[0].u;
        s1_axis_tvalid = 1'b1;
    endtask

    // One clock: observe at negedge, then update drivers just after posedge.
    task automatic tick();
        bit    s1_acc;
        beat_t cur;
        beat_t b;
        @(negedge clk);
        cur = cur_out();
        if (prev_stall && cur !== prev_beat) stall_err++;
        prev_stall = m_axis_tvalid && !m_axis_tready;
        prev_beat  = cur;
        if (m_axis_tvalid && m_axis_tready) obs.push_back(cur);
        s1_acc = s1_axis_tvalid && s1_axis_tready;
        @(posedge clk);
        #1;
        if (s1_acc) begin
            exp1.push_back(s1_pend.pop_front());
            s1_axis_tvalid = 1'b0;
        end
        if (!s1_axis_tvalid && s1_pend.size() > 0 &&
            $urandom_range(0, 99) >= s1_gap) drive1();
        m_axis_tready  = ($urandom_range(0, 99) < mr_rate);
        s0_axis_tvalid = 1'b0;
        if (s0_pend.size() > 0 && s0_axis_tready &&
            $urandom_range(0, 99) < s0_rate) begin
            b = s0_pend.pop_front();
            inject0(b, 1'b1);
        end
    endtask

    task automatic drain(string tag, int bound);
        int n = 0;
        while ((s0_pend.size() > 0 || s1_pend.size() > 0 || s1_axis_tvalid ||
                obs.size() < exp0.size() + exp1.size()) && n < bound) begin
            tick();
            n++;
        end
        chk({tag, " drain in time"}, 64'(n < bound), 64'd1);
        repeat (4) tick();
    endtask

    // Per-port order and content, plus no packet interleaving on m.
    task automatic check_stream(string tag);
        beat_t o0[$];
        beat_t o1[$];
        int bad0 = 0;
        int bad1 = 0;
        int il   = 0;
        int cur  = -1;
        foreach (obs[i]) begin
            if (obs[i].d[DW-1]) o1.push_back(obs[i]);
            else                o0.push_back(obs[i]);
            if (cur != -1 && int'(obs[i].d[DW-1]) != cur) il++;
            cur = obs[i].l ? -1 : int'(obs[i].d[DW-1]);
        end
        chk({tag, " p0 count"}, 64'(o0.size()), 64'(exp0.size()));
        chk({tag, " p1 count"}, 64'(o1.size()), 64'(exp1.size()));
        for (int i = 0; i < o0.size() && i < exp0.size(); i++)
            if (o0[i] !== exp0[i]) bad0++;
        for (int i = 0; i < o1.size() && i < exp1.size(); i++)
            if (o1[i] !== exp1[i]) bad1++;
        chk({tag, " p0 beats"}, 64'(bad0), 64'd0);
        chk({tag, " p1 beats"}, 64'(bad1), 64'd0);
        chk({tag, " interleave"}, 64'(il), 64'd0);
    endtask

    task automatic clear();
        obs.delete();
        exp0.delete();
        exp1.delete();
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        beat_t b;
        int    n;
        int    bad;
        logic [3:0] ps;

        s0_axis_tdata  = '0;
        s0_axis_tkeep  = '0;
        s0_axis_tlast  = 1'b0;
        s0_axis_tuser  = '0;
        s0_axis_tvalid = 1'b0;
        s1_axis_tdata  = '0;
        s1_axis_tkeep  = '0;
        s1_axis_tlast  = 1'b0;
        s1_axis_tuser  = '0;
        s1_axis_tvalid = 1'b0;
        m_axis_tready  = 1'b1;

        // Reset state.
        repeat (3) @(posedge clk);
        #1;
        chk("rst m_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("rst m_fields", 64'(|{m_axis_tdata, m_axis_tkeep,
                                  m_axis_tuser, m_axis_tlast}), 64'd0);
        chk("rst s0_tready", 64'(s0_axis_tready), 64'd1);
        chk("rst s1_tready", 64'(s1_axis_tready), 64'd0);
        chk("rst overflow", 64'(s0_overflow), 64'd0);
        rst = 1'b1;
        tick();

        // Single-beat s0 packet: two-cycle latency.
        b = mk(1'b0, 0, 1'b1);
        b.d[31:0] = 32'hDEADBEEF;
        s0_pend.push_back(b);
        tick();
        tick();
        chk("t1 m_tvalid +1", 64'(m_axis_tvalid), 64'd0);
        tick();
        chk("t1 m_tvalid +2", 64'(m_axis_tvalid), 64'd1);
        chk("t1 tdata", 64'(m_axis_tdata[31:0]), 64'hDEADBEEF);
        chk("t1 overflow", 64'(s0_overflow), 64'd0);
        drain("t1", 50);
        check_stream("t1");
        clear();

        // 3-beat s1 packet with an s0 beat arriving mid-packet.
        for (int i = 0; i < 3; i++) s1_pend.push_back(mk(1'b1, i, i == 2));
        tick();
        tick();
        inject0(mk(1'b0, 1, 1'b1), 1'b1);
        drain("t2", 50);
        ps = '0;
        for (int i = 0; i < obs.size() && i < 4; i++) ps[3-i] = obs[i].d[DW-1];
        chk("t2 order", 64'(ps), 64'b1110);
        check_stream("t2");
        clear();

        // Both ports continuously requesting 1-beat packets.
        for (int i = 0; i < 16; i++) begin
            s0_pend.push_back(mk(1'b0, i, 1'b1));
            s1_pend.push_back(mk(1'b1, i, 1'b1));
        end
        drain("t3", 200);
        bad = 0;
`ifdef PCIE_CC_ARB_FIXED_PRIO_EN
        for (int i = 1; i <= 16 && i < obs.size(); i++)
            if (obs[i].d[DW-1] != 1'b0) bad++;
`else
        for (int i = 1; i < 32 && i < obs.size(); i++)
            if (obs[i].d[DW-1] == obs[i-1].d[DW-1]) bad++;
`endif
        chk("t3 grant pattern", 64'(bad), 64'd0);
        check_stream("t3");
        clear();

        // 5-beat s1 packet under random m_tready.
        stall_err = 0;
        mr_rate = 50;
        for (int i = 0; i < 5; i++) s1_pend.push_back(mk(1'b1, i, i == 4));
        drain("t4", 200);
        chk("t4 stall stable", 64'(stall_err), 64'd0);
        check_stream("t4");
        clear();
        mr_rate = 100;
        tick();

        // Overflow: output register held, 6 s0 pulses into depth 4.
        mr_rate = 0;
        m_axis_tready = 1'b0;
        s1_pend.push_back(mk(1'b1, 0, 1'b1));
        drive1();
        tick();
        for (int k = 0; k < 6; k++) begin
            inject0(mk(1'b0, k, 1'b1), k < 4);
            tick();
        end
        chk("t5 overflow", 64'(s0_overflow), 64'd1);
        chk("t5 s0_tready full", 64'(s0_axis_tready), 64'd0);
        chk("t5 m_tvalid held", 64'(m_axis_tvalid), 64'd1);
        repeat (3) tick();
        mr_rate = 100;
        m_axis_tready = 1'b1;
        inject0(mk(1'b0, 6, 1'b1), 1'b1);
        drain("t5", 100);
        check_stream("t5");
        chk("t5 stall stable", 64'(stall_err), 64'd0);
        clear();

        // Reset asserted mid-GNT1 with a beat parked in the FIFO.
        for (int i = 0; i < 5; i++) s1_pend.push_back(mk(1'b1, i, i == 4));
        n = 0;
        while (exp1.size() < 2 && n < 50) begin
            tick();
            n++;
        end
        chk("t6 mid packet", 64'(exp1.size()), 64'd2);
        inject0(mk(1'b0, 9, 1'b1), 1'b0);
        tick();
        rst = 1'b0;
        #1;
        chk("t6 m_tvalid", 64'(m_axis_tvalid), 64'd0);
        chk("t6 m_fields", 64'(|{m_axis_tdata, m_axis_tkeep,
                                 m_axis_tuser, m_axis_tlast}), 64'd0);
        chk("t6 s1_tready", 64'(s1_axis_tready), 64'd0);
        chk("t6 s0_tready", 64'(s0_axis_tready), 64'd1);
        chk("t6 overflow", 64'(s0_overflow), 64'd0);
        s1_pend.delete();
        s1_axis_tvalid = 1'b0;
        clear();
        repeat (2) tick();
        rst = 1'b1;
        inject0(mk(1'b0, 20, 1'b1), 1'b1);
        tick();
        s1_pend.push_back(mk(1'b1, 20, 1'b1));
        drive1();
        drain("t6", 50);
        ps = '0;
        for (int i = 0; i < obs.size() && i < 2; i++) ps[1-i] = obs[i].d[DW-1];
        chk("t6 tie after reset", 64'(ps), 64'b0001);
        check_stream("t6");
        clear();

        // Random mixed traffic on both ports.
        stall_err = 0;
        mr_rate = 70;
        s1_gap  = 30;
        s0_rate = 40;
        for (int p = 0; p < 20; p++) begin
            n = $urandom_range(1, 4);
            for (int i = 0; i < n; i++)
                s1_pend.push_back(mk(1'b1, p * 8 + i, i == n - 1));
            n = $urandom_range(1, 3);
            for (int i = 0; i < n; i++)
                s0_pend.push_back(mk(1'b0, p * 8 + i, i == n - 1));
        end
        drain("t7", 3000);
        check_stream("t7");
        chk("t7 stall stable", 64'(stall_err), 64'd0);
        chk("t7 overflow", 64'(s0_overflow), 64'd0);
        clear();

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
